axi_aw_burst_addr_gen: RTL

Slave-side write-address burst expander. It sits directly downstream of the AXI write-address channel (`aw*` signals of the `ovc_if` bundle). It accepts one AW transfer at a time and emits one address per data beat (FIXED, INCR or WRAP) to the write-data/memory stage. It also flags protocol-illegal bursts.

---
 rtl/axi_aw_burst_addr_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/axi_aw_burst_addr_gen.sv
// AXI write-address burst expander: accepts one AW transfer and emits one
// address per data beat (FIXED / INCR / WRAP), flagging illegal bursts.
module axi_aw_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [2:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [7:0]            beat_idx,
  output logic                  beat_last,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic                  burst_err
);

  localparam int MAX_SIZE = $clog2(DATA_BYTES);

  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_t;

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d, aw_mode;
  logic [ADDR_WIDTH-1:0] step_q, step_d, lo_q, lo_d, hi_q, hi_d;
  logic [7:0]            len_q, len_d;
  logic                  awready_d, valid_d, last_d, err_d;
  logic [ADDR_WIDTH-1:0] addr_d, next_addr;
  logic [7:0]            idx_d;

  // Accept-time terms, evaluated on the raw AW fields.
  logic [ADDR_WIDTH-1:0] aw_s, aw_span, aw_lo, aw_last_incr;
  logic [8:0]            aw_n;
  logic                  wrap_ok, aw_err;

  always_comb begin
    aw_s         = ADDR_WIDTH'(1) << awsize;
    aw_n         = {1'b0, awlen} + 9'd1;
    aw_span      = ADDR_WIDTH'(aw_n) << awsize;
    aw_lo        = awaddr & ~(aw_span - ADDR_WIDTH'(1));
    aw_last_incr = (awaddr & ~(aw_s - ADDR_WIDTH'(1))) + (ADDR_WIDTH'(awlen) << awsize);
    wrap_ok      = (awlen == 8'd1 || awlen == 8'd3 || awlen == 8'd7 || awlen == 8'd15) &&
                   ((awaddr & (aw_s - ADDR_WIDTH'(1))) == '0);
    case (awburst)
      3'd0:    aw_mode = MODE_FIXED;
      3'd2:    aw_mode = wrap_ok ? MODE_WRAP : MODE_INCR;
      default: aw_mode = MODE_INCR;
    endcase
    aw_err = (awsize > 3'(MAX_SIZE)) ||
             (awburst > 3'd2) ||
             (awburst == 3'd2 && !wrap_ok) ||
             (awburst == 3'd0 && awlen > 8'd15) ||
             (aw_mode == MODE_INCR &&
              aw_last_incr[ADDR_WIDTH-1:12] != awaddr[ADDR_WIDTH-1:12]);
  end

  always_comb begin
    case (mode_q)
      MODE_FIXED: next_addr = beat_addr;
      MODE_WRAP:  next_addr = ((beat_addr + step_q) == hi_q) ? lo_q : beat_addr + step_q;
      default:    next_addr = (beat_addr & ~(step_q - ADDR_WIDTH'(1))) + step_q;
    endcase
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    step_d    = step_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    len_d     = len_q;
    awready_d = awready;
    valid_d   = beat_valid;
    last_d    = beat_last;
    addr_d    = beat_addr;
    idx_d     = beat_idx;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready) begin
          state_d   = BURST;
          mode_d    = aw_mode;
          step_d    = aw_s;
          lo_d      = aw_lo;
          hi_d      = aw_lo + aw_span;
          len_d     = awlen;
          awready_d = 1'b0;
          valid_d   = 1'b1;
          addr_d    = awaddr;
          idx_d     = 8'd0;
          last_d    = (awlen == 8'd0);
          err_d     = aw_err;
        end
      end
      default: begin
        if (beat_ready) begin
          if (beat_last) begin
            state_d   = IDLE;
            awready_d = 1'b1;
            valid_d   = 1'b0;
            last_d    = 1'b0;
          end else begin
            addr_d = next_addr;
            idx_d  = beat_idx + 8'd1;
            last_d = ((beat_idx + 8'd1) == len_q);
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      mode_q     <= MODE_INCR;
      step_q     <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      len_q      <= '0;
      awready    <= 1'b0;
      beat_valid <= 1'b0;
      beat_last  <= 1'b0;
      beat_addr  <= '0;
      beat_idx   <= '0;
      burst_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      len_q      <= len_d;
      awready    <= awready_d;
      beat_valid <= valid_d;
      beat_last  <= last_d;
      beat_addr  <= addr_d;
      beat_idx   <= idx_d;
      burst_err  <= err_d;
    end
  end

endmodule
